// File: rtl/dir_pkg.sv
// Direction encodings and encoder FSM states shared with the movement block.
// Direction bit order is {right,left,down,up}; all-zero means idle.
package dir_pkg;

  localparam logic [3:0] DIR_IDLE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw button; 2 + DEBOUNCE_CYCLES-1 cycles to level change.
// No backpressure: the debounced level is a free-running status output.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the sample where the counter would reach DEBOUNCE_CYCLES-1.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 2)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/dir_button_encoder.sv
// Debounced four-button direction encoder with auto-repeat; press to cmd_valid = DEBOUNCE_CYCLES+4 cycles.
// cmd_valid/cmd_dir hold until accepted; raises while pending are dropped. DIAGONAL_EN allows one vertical + one horizontal bit.
module dir_button_encoder
  import dir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 8_388_608
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       cmd_valid,
  output logic [3:0] cmd_dir,
  input  logic       cmd_ready,
  output logic [3:0] held_dir
);

  localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  logic          up_db, down_db, left_db, right_db;
  logic [1:0]    vert, horiz;
  logic [3:0]    resolved;
  logic [3:0]    held_q;
  state_e        state_q, state_d;
  logic [3:0]    dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          raise;
  logic          cmd_valid_q, cmd_valid_d;
  logic [3:0]    cmd_dir_q, cmd_dir_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),    .level_o(up_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(clk), .rst_n(rst_n), .btn_i(btn_down),  .level_o(down_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(clk), .rst_n(rst_n), .btn_i(btn_left),  .level_o(left_db));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(clk), .rst_n(rst_n), .btn_i(btn_right), .level_o(right_db));

  always_comb begin
    vert  = {down_db, up_db};
    horiz = {right_db, left_db};
    if (&vert)  vert  = 2'b00;
    if (&horiz) horiz = 2'b00;
`ifdef DIAGONAL_EN
`else
    if (vert != 2'b00) horiz = 2'b00;
`endif
    resolved = {horiz, vert};
  end

  // Release or a new direction overrides whatever the state machine was doing.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    raise   = 1'b0;
    if (held_q == DIR_IDLE) begin
      state_d = ST_IDLE;
      dir_d   = DIR_IDLE;
    end else if (held_q != dir_q) begin
      state_d = ST_PRESS;
      dir_d   = held_q;
    end else begin
      case (state_q)
        ST_PRESS: begin
          raise   = 1'b1;
          timer_d = '0;
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            raise   = 1'b1;
            timer_d = '0;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
            raise   = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_dir_d   = cmd_dir_q;
    if (raise && (!cmd_valid_q || cmd_ready)) begin
      cmd_valid_d = 1'b1;
      cmd_dir_d   = dir_q;
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      cmd_dir_d   = DIR_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q      <= DIR_IDLE;
      state_q     <= ST_IDLE;
      dir_q       <= DIR_IDLE;
      timer_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= DIR_IDLE;
    end else begin
      held_q      <= resolved;
      state_q     <= state_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dir_q   <= cmd_dir_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_dir   = cmd_dir_q;
  assign held_dir  = held_q;

endmodule

// File: tb/tb_dir_button_encoder.sv
// Bench for dir_button_encoder with short debounce/repeat timing; accepted commands are checked
// against a queue of expected {direction, cycle} entries.
module tb_dir_button_encoder;

  logic       clk;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       cmd_valid;
  logic [3:0] cmd_dir;
  logic       cmd_ready;
  logic [3:0] held_dir;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] dir;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] held_nd;
    logic [3:0] held_dg;
  } vec_t;
  vec_t vecs[14];

  dir_button_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready),
    .held_dir(held_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance happens at the next posedge whenever valid&ready are seen here.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd: got dir=%b at cycle %0d, expected no command", cmd_dir, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cmd_dir !== mon_e.dir || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL cmd: got dir=%b at cycle %0d, expected dir=%b at cycle %0d",
                   cmd_dir, cyc, mon_e.dir, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic push(input logic [3:0] d, input int c);
    exp_t e;
    e.dir = d;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int         c;
    int         s;
    int         nbad;
    logic [3:0] exp_h;
    logic [3:0] prev;

    // {right,left,down,up} buttons, expected held_dir without / with diagonals
    vecs[0]  = '{4'b0001, 4'b0001, 4'b0001};
    vecs[1]  = '{4'b0011, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0111, 4'b0100, 4'b0100};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0101, 4'b0001, 4'b0101};
    vecs[5]  = '{4'b1100, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b1110, 4'b0010, 4'b0010};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b1010, 4'b0010, 4'b1010};
    vecs[9]  = '{4'b1000, 4'b1000, 4'b1000};
    vecs[10] = '{4'b0100, 4'b0100, 4'b0100};
    vecs[11] = '{4'b1111, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0010, 4'b0010, 4'b0010};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000};

    rst_n     = 1'b0;
    cmd_ready = 1'b1;
    set_btn(4'b0000);
    tick(3);
    chk4("rst_valid", {3'b000, cmd_valid}, 4'b0000);
    chk4("rst_dir", cmd_dir, 4'b0000);
    chk4("rst_held", held_dir, 4'b0000);
    rst_n = 1'b1;
    tick(2);

    // Resolution table: each pattern held 12 cycles, new nonzero direction -> one command 8 cycles later.
    prev = 4'b0000;
    for (int i = 0; i < 14; i++) begin
      c = cyc;
      set_btn(vecs[i].btn);
`ifdef DIAGONAL_EN
      exp_h = vecs[i].held_dg;
`else
      exp_h = vecs[i].held_nd;
`endif
      if (exp_h != 4'b0000 && exp_h != prev) push(exp_h, c + 8);
      prev = exp_h;
      tick(11);
      chk4($sformatf("held_vec%0d", i), held_dir, exp_h);
      tick(1);
    end
    tick(20);
    chk_int("table_pending", sb.size(), 0);

    // Bounce on up: 2-cycle toggles never debounce; final stable press yields one command.
    for (int k = 0; k < 10; k++) begin
      set_btn((k % 2 == 0) ? 4'b0001 : 4'b0000);
      tick(2);
    end
    s = cyc;
    set_btn(4'b0001);
    push(4'b0001, s + 8);
    tick(6);
    chk4("bounce_held", held_dir, 4'b0001);
    tick(4);
    set_btn(4'b0000);
    tick(20);
    chk_int("bounce_pending", sb.size(), 0);

    // Auto-repeat on right for 100 cycles.
    c = cyc;
    set_btn(4'b1000);
    push(4'b1000, c + 8);
    push(4'b1000, c + 28);
    for (int t = c + 36; t <= c + 100; t += 8) push(4'b1000, t);
    tick(100);
    set_btn(4'b0000);
    tick(30);
    chk_int("repeat_pending", sb.size(), 0);
    chk4("repeat_held_released", held_dir, 4'b0000);

    // Backpressure on down: command held stable, single acceptance, then normal repeat cadence.
    c = cyc;
    cmd_ready = 1'b0;
    set_btn(4'b0010);
    tick(9);
    nbad = 0;
    for (int k = 0; k < 31; k++) begin
      if (cmd_valid !== 1'b1 || cmd_dir !== 4'b0010) nbad++;
      tick(1);
    end
    chk_int("bp_stable_cycles_bad", nbad, 0);
    push(4'b0010, c + 40);
    push(4'b0010, c + 44);
    cmd_ready = 1'b1;
    tick(4);
    set_btn(4'b0000);
    tick(30);
    chk_int("bp_pending", sb.size(), 0);

    // Reset in REPEAT with a pending command; button stays held through reset.
    c = cyc;
    cmd_ready = 1'b0;
    set_btn(4'b1000);
    tick(30);
    chk4("mid_pre_valid", {3'b000, cmd_valid}, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk4("mid_rst_valid", {3'b000, cmd_valid}, 4'b0000);
    chk4("mid_rst_held", held_dir, 4'b0000);
    tick(2);
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    push(4'b1000, c + 40);
    tick(5);
    chk4("post_rst_held_early", held_dir, 4'b0000);
    tick(7);
    set_btn(4'b0000);
    tick(20);
    chk_int("rst_pending", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
